// File: rtl/alu_pkg.sv
// Shared types and op-classification helpers for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      FOP_ADD   = 4'd0,
      FOP_SUB   = 4'd1,
      FOP_SLL   = 4'd2,
      FOP_SRL   = 4'd3,
      FOP_SRA   = 4'd4,
      FOP_AND   = 4'd5,
      FOP_OR    = 4'd6,
      FOP_XOR   = 4'd7,
      FOP_IMM   = 4'd8,
      FOP_MUL   = 4'd9,
      FOP_MULHU = 4'd10,
      FOP_DIVU  = 4'd11,
      FOP_REMU  = 4'd12
   } fop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_t;

   function automatic logic is_iterative(input logic [3:0] f);
      return (f == FOP_MUL) || (f == FOP_MULHU) || (f == FOP_DIVU) || (f == FOP_REMU);
   endfunction

   function automatic logic is_divide(input logic [3:0] f);
      return (f == FOP_DIVU) || (f == FOP_REMU);
   endfunction

   // MULHU takes the upper product half; REMU takes the remainder, kept in the same register.
   function automatic logic selects_high(input logic [3:0] f);
      return (f == FOP_MULHU) || (f == FOP_REMU);
   endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Valid/ready operand and result bus between the execute stage and the ALU.
interface alu_mc_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] rda;
   logic [WIDTH-1:0] rdb;
   logic [3:0]       fop;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             Z;
   logic             N;
   logic             C;
   logic             V;

   modport master (
      output in_valid, rda, rdb, fop, out_ready,
      input  in_ready, out_valid, result, Z, N, C, V
   );

   modport slave (
      input  in_valid, rda, rdb, fop, out_ready,
      output in_ready, out_valid, result, Z, N, C, V
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider sharing a hi:lo register pair.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic             sel_hi,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             done,
   output logic [WIDTH-1:0] res
);
   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0]   count_reg;
   logic             active_reg;
   logic             is_div_reg;
   logic             sel_hi_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [WIDTH-1:0] hi_next;
   logic [WIDTH-1:0] lo_next;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   // Multiply: hi accumulates, lo holds the multiplier and fills with product bits.
   // Divide: hi is the partial remainder, lo shifts the dividend out and quotient bits in.
   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
      div_shift = {hi_reg, lo_reg[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, a_reg});
      div_diff  = div_shift[WIDTH-1:0] - a_reg;
      if (is_div_reg) begin
         hi_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
         lo_next = {lo_reg[WIDTH-2:0], div_ge};
      end else begin
         hi_next = mul_sum[WIDTH:1];
         lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= '0;
         active_reg <= 1'b0;
         is_div_reg <= 1'b0;
         sel_hi_reg <= 1'b0;
         a_reg      <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else if (start) begin
         count_reg  <= SHW'(WIDTH - 1);
         active_reg <= 1'b1;
         is_div_reg <= is_div;
         sel_hi_reg <= sel_hi;
         a_reg      <= is_div ? opb : opa;
         hi_reg     <= '0;
         lo_reg     <= is_div ? opa : opb;
      end else if (active_reg) begin
         hi_reg <= hi_next;
         lo_reg <= lo_next;
         if (count_reg == '0) begin
            active_reg <= 1'b0;
         end else begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   // The final iteration's result is presented combinationally so the owner can register it on the same edge.
   assign done = active_reg && (count_reg == '0);
   assign res  = sel_hi_reg ? hi_next : lo_next;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: handshake FSM, single-cycle ops and flag registers.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     rst,
   alu_mc_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   alu_state_t       state_reg;
   alu_state_t       state_next;
   logic             accept;
   logic             goes_busy;
   logic             start;
   logic             iter_done;
   logic             load;
   logic [WIDTH-1:0] iter_res;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] fin_res;
   logic             sc_c;
   logic             sc_v;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   sub_diff;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] result_reg;
   logic             z_reg;
   logic             n_reg;
   logic             c_reg;
   logic             v_reg;

   // A zero divisor never enters the iterative engine.
   assign goes_busy = is_iterative(bus.fop) && !(is_divide(bus.fop) && (bus.rdb == '0));
   assign accept    = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = goes_busy ? BUSY : DONE;
         BUSY: if (iter_done) state_next = DONE;
         DONE: if (accept) state_next = goes_busy ? BUSY : DONE;
               else if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
      bus.out_valid = (state_reg == DONE);
      start         = bus.in_valid && bus.in_ready && goes_busy;
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (is_divide(bus.fop)),
      .sel_hi (selects_high(bus.fop)),
      .opa    (bus.rda),
      .opb    (bus.rdb),
      .done   (iter_done),
      .res    (iter_res)
   );

   always_comb begin
      shamt    = bus.rdb[SHW-1:0];
      add_sum  = {1'b0, bus.rda} + {1'b0, bus.rdb};
      sub_diff = {1'b0, bus.rda} + {1'b0, ~bus.rdb} + (WIDTH+1)'(1);
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      case (bus.fop)
         FOP_ADD: begin
            sc_res = add_sum[WIDTH-1:0];
            sc_c   = add_sum[WIDTH];
            sc_v   = (bus.rda[WIDTH-1] == bus.rdb[WIDTH-1]) && (add_sum[WIDTH-1] != bus.rda[WIDTH-1]);
         end
         FOP_SUB: begin
            sc_res = sub_diff[WIDTH-1:0];
            sc_c   = sub_diff[WIDTH];
            sc_v   = (bus.rda[WIDTH-1] != bus.rdb[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.rda[WIDTH-1]);
         end
         FOP_SLL:  sc_res = bus.rda << shamt;
         FOP_SRL:  sc_res = bus.rda >> shamt;
         FOP_SRA:  sc_res = WIDTH'($signed(bus.rda) >>> shamt);
         FOP_AND:  sc_res = bus.rda & bus.rdb;
         FOP_OR:   sc_res = bus.rda | bus.rdb;
         FOP_XOR:  sc_res = bus.rda ^ bus.rdb;
         FOP_IMM:  sc_res = bus.rdb;
         FOP_DIVU: sc_res = '1;
         FOP_REMU: sc_res = bus.rda;
         default:  sc_res = '0;
      endcase
   end

   assign load    = (accept && !goes_busy) || ((state_reg == BUSY) && iter_done);
   assign fin_res = (state_reg == BUSY) ? iter_res : sc_res;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_reg <= '0;
         z_reg      <= 1'b0;
         n_reg      <= 1'b0;
         c_reg      <= 1'b0;
         v_reg      <= 1'b0;
      end else if (load) begin
         result_reg <= fin_res;
         z_reg      <= (fin_res == '0);
         n_reg      <= fin_res[WIDTH-1];
         c_reg      <= (state_reg == BUSY) ? 1'b0 : sc_c;
         v_reg      <= (state_reg == BUSY) ? 1'b0 : sc_v;
      end
   end

   assign bus.result = result_reg;
   assign bus.Z      = z_reg;
   assign bus.N      = n_reg;
   assign bus.C      = c_reg;
   assign bus.V      = v_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32 with hand-computed results, flags and latencies.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   stale;

   always #5 clk = ~clk;

   alu_mc_if #(.WIDTH(W)) bus ();

   alu_mc #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble the inputs after accept, then measure latency and check result/flags.
   task automatic run(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_res,
                      input logic [3:0] exp_f, input int exp_lat);
      int lat;
      bus.fop      = op;
      bus.rda      = a;
      bus.rdb      = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.rda      = 32'hDEADBEEF;
      bus.rdb      = 32'h0BADF00D;
      bus.fop      = FOP_ADD;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1 && exp_lat > 0) chk({tag, " busy_in_ready"}, 64'(bus.in_ready), 64'(0));
      end
      chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
      chk({tag, " flags_ZNCV"}, 64'({bus.Z, bus.N, bus.C, bus.V}), 64'(exp_f));
      $display("txn %s op=%0d a=%h b=%h result=%h ZNCV=%b latency=%0d",
               tag, op, a, b, bus.result, {bus.Z, bus.N, bus.C, bus.V}, lat);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.rda       = '0;
      bus.rdb       = '0;
      bus.fop       = FOP_ADD;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 64'(bus.out_valid), 64'(0));
      chk("reset result", 64'(bus.result), 64'(0));
      chk("reset flags", 64'({bus.Z, bus.N, bus.C, bus.V}), 64'(0));
      rst = 1'b0;
      #1;
      chk("reset in_ready", 64'(bus.in_ready), 64'(1));

      run("add_wrap",  FOP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        4'b1010, 0);
      run("sub_ovf",   FOP_SUB,   32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0011, 0);
      run("sub_neg",   FOP_SUB,   32'd762,      32'd1000,     32'hFFFFFF12, 4'b0100, 0);
      run("sra",       FOP_SRA,   32'h80000001, 32'h25,       32'hFC000000, 4'b0100, 0);
      run("sll",       FOP_SLL,   32'd7,        32'd2,        32'd28,       4'b0000, 0);
      run("srl",       FOP_SRL,   32'h80000000, 32'h21,       32'h40000000, 4'b0000, 0);
      run("xor",       FOP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, 0);
      run("imm",       FOP_IMM,   32'h12345678, 32'h80000000, 32'h80000000, 4'b0100, 0);
      run("undef13",   4'd13,     32'h1234,     32'h5678,     32'h0,        4'b1000, 0);
      run("mulhu",     FOP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b0100, W);
      run("mul",       FOP_MUL,   32'd14,       32'd3,        32'd42,       4'b0000, W);
      run("divu",      FOP_DIVU,  32'd100,      32'd7,        32'd14,       4'b0000, W);
      run("remu",      FOP_REMU,  32'd100,      32'd7,        32'd2,        4'b0000, W);
      run("divu_zero", FOP_DIVU,  32'd55,       32'd0,        32'hFFFFFFFF, 4'b0100, 0);
      run("remu_zero", FOP_REMU,  32'd55,       32'd0,        32'd55,       4'b0000, 0);

      // Back-pressure: hold the result, then hand over to a new op in the same cycle.
      bus.fop      = FOP_REMU;
      bus.rda      = 32'd55;
      bus.rdb      = 32'd0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("stall out_valid", 64'(bus.out_valid), 64'(1));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall result", 64'(bus.result), 64'(55));
         chk("stall in_ready", 64'(bus.in_ready), 64'(0));
      end
      $display("txn stall_hold result=%h held 5 cycles", bus.result);
      bus.fop       = FOP_ADD;
      bus.rda       = 32'd2;
      bus.rdb       = 32'd2;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("handover in_ready", 64'(bus.in_ready), 64'(1));
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("handover out_valid", 64'(bus.out_valid), 64'(1));
      chk("handover result", 64'(bus.result), 64'(4));
      chk("handover flags", 64'({bus.Z, bus.N, bus.C, bus.V}), 64'(0));
      $display("txn handover_add a=2 b=2 result=%h", bus.result);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Reset in the middle of an iterative divide.
      bus.fop      = FOP_DIVU;
      bus.rda      = 32'd100;
      bus.rdb      = 32'd7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midop_rst out_valid", 64'(bus.out_valid), 64'(0));
      chk("midop_rst result", 64'(bus.result), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("post_rst in_ready", 64'(bus.in_ready), 64'(1));
      stale = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) stale++;
      end
      chk("post_rst no_stale", 64'(stale), 64'(0));
      $display("txn midop_reset divu 100/7 abandoned stale_cycles=%0d", stale);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
